// File: rtl/frost32_cpu_pkg.sv
// Frost32Cpu memory-port access enums shared by the CPU and its memory bridge.
package PkgFrost32Cpu;
    typedef enum logic {
        DiatRead  = 1'b0,
        DiatWrite = 1'b1
    } DataInoutAccessType;

    typedef enum logic [1:0] {
        Dias8  = 2'b00,
        Dias16 = 2'b01,
        Dias32 = 2'b10
    } DataInoutAccessSize;
endpackage

// File: rtl/frost32_mem_bridge_pkg.sv
// Bridge FSM states, read-latency tracker width and access-size decoding.
package PkgFrost32MemBridge;
    import PkgFrost32Cpu::*;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } state_t;

    // Widest read-latency shift register; MEM_RD_LATENCY must not exceed it.
    localparam int LAT_SR_W = 3;

    // Byte count of an access; the unused encoding 2'b11 behaves as a word.
    function automatic logic [2:0] size_to_n(input logic [1:0] sz);
        case (sz)
            Dias8:   return 3'd1;
            Dias16:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction
endpackage

// File: rtl/frost32_mem_rd_tracker.sv
// Flags the cycle a read byte returns (LATENCY cycles after i_re) and counts captures.
// Registered flag, no backpressure; i_clr restarts the capture count.
module frost32_mem_rd_tracker
    import PkgFrost32MemBridge::*;
#(
    parameter int LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic       i_re,
    output logic       o_vld,
    output logic [2:0] o_cnt
);
    logic [LAT_SR_W-1:0] r_sr;
    logic [LAT_SR_W-1:0] w_sr_nxt;
    logic [2:0]          r_cnt;

    // Enter at bit LATENCY-1 and drain toward bit 0, so bit 0 marks the return cycle.
    always_comb begin
        w_sr_nxt              = r_sr >> 1;
        w_sr_nxt[LATENCY-1]   = i_re;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr  <= '0;
            r_cnt <= 3'd0;
        end else begin
            r_sr <= w_sr_nxt;
            if (i_clr)
                r_cnt <= 3'd0;
            else if (o_vld)
                r_cnt <= r_cnt + 3'd1;
        end
    end

    assign o_vld = r_sr[0];
    assign o_cnt = r_cnt;
endmodule

// File: rtl/frost32_mem_bridge.sv
// Runs one 8/16/32-bit CPU access as big-endian byte cycles on a byte RAM; CPU stalls on cpu_busy.
// Optional FROST32_MEM_BRIDGE_ALIGN_CHECK_EN faults misaligned accesses without touching RAM.
module frost32_mem_bridge
    import PkgFrost32Cpu::*;
    import PkgFrost32MemBridge::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int MEM_RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_wdata,
    input  logic                  cpu_access_type,
    input  logic [1:0]            cpu_access_size,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_busy,
    output logic                  cpu_done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [7:0]            mem_rdata,
    output logic                  cpu_fault
);
    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wsh;
    logic [23:0]           r_acc;
    logic [31:0]           r_rdata;
    logic                  r_is_wr;
    logic [1:0]            r_idx;
    logic [1:0]            r_last;

    logic [2:0]            w_n;
    logic                  w_accept;
    logic                  w_issue;
    logic                  w_misalign;
    logic [31:0]           w_wsh_init;
    logic [31:0]           w_acc_nxt;
    logic                  w_rd_vld;
    logic [2:0]            w_rd_cnt;
    logic                  w_unused_addr;

    assign w_n           = size_to_n(cpu_access_size);
    assign w_accept      = (r_state == StIdle) && cpu_req;
    assign w_issue       = (r_state == StIssue);
    assign w_acc_nxt     = {r_acc, mem_rdata};
    assign w_unused_addr = ^cpu_addr[31:ADDR_WIDTH];

    // Left-justify write data so the outgoing byte is always r_wsh[31:24].
    always_comb begin
        w_wsh_init = cpu_wdata;
        case (cpu_access_size)
            Dias8:   w_wsh_init = {cpu_wdata[7:0], 24'h0};
            Dias16:  w_wsh_init = {cpu_wdata[15:0], 16'h0};
            default: w_wsh_init = cpu_wdata;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:  if (cpu_req) w_state_nxt = w_misalign ? StDone : StIssue;
            StIssue: if (r_idx == r_last) w_state_nxt = r_is_wr ? StDone : StDrain;
            StDrain: if (w_rd_vld && (w_rd_cnt == {1'b0, r_last})) w_state_nxt = StDone;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_addr  <= '0;
            r_wsh   <= 32'h0;
            r_acc   <= 24'h0;
            r_rdata <= 32'h0;
            r_is_wr <= 1'b0;
            r_idx   <= 2'd0;
            r_last  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr  <= cpu_addr[ADDR_WIDTH-1:0];
                r_wsh   <= w_wsh_init;
                r_acc   <= 24'h0;
                r_is_wr <= (cpu_access_type == DiatWrite);
                r_idx   <= 2'd0;
                r_last  <= 2'(w_n - 3'd1);
            end else begin
                if (w_issue) begin
                    r_idx <= r_idx + 2'd1;
                    r_wsh <= {r_wsh[23:0], 8'h00};
                end
                if (w_rd_vld)
                    r_acc <= w_acc_nxt[23:0];
                // Publish the word together with its final byte so DONE sees it.
                if ((r_state == StDrain) && (w_state_nxt == StDone))
                    r_rdata <= w_acc_nxt;
            end
        end
    end

    frost32_mem_rd_tracker #(
        .LATENCY (MEM_RD_LATENCY)
    ) u_rd_tracker (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_accept),
        .i_re  (mem_re),
        .o_vld (w_rd_vld),
        .o_cnt (w_rd_cnt)
    );

`ifdef FROST32_MEM_BRIDGE_ALIGN_CHECK_EN
    logic r_fault;

    assign w_misalign = ((w_n == 3'd4) && (cpu_addr[1:0] != 2'b00)) ||
                        ((w_n == 3'd2) && cpu_addr[0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_fault <= 1'b0;
        else if (w_accept)
            r_fault <= w_misalign;
    end

    assign cpu_fault = (r_state == StDone) && r_fault;
`else
    assign w_misalign = 1'b0;
    assign cpu_fault  = 1'b0;
`endif

    assign cpu_busy  = (r_state != StIdle);
    assign cpu_done  = (r_state == StDone);
    assign cpu_rdata = r_rdata;
    assign mem_we    = w_issue && r_is_wr;
    assign mem_re    = w_issue && !r_is_wr;
    assign mem_addr  = w_issue ? (r_addr + ADDR_WIDTH'(r_idx)) : '0;
    assign mem_wdata = mem_we ? r_wsh[31:24] : 8'h00;
endmodule
